// File: rtl/sprite_plotter.sv
// sprite_plotter: erases the previous sprite and draws a new one pixel by pixel,
// with a one-deep pending request register and screen-edge clipping.
module sprite_plotter #(
    parameter int SPR_W = 4,
    parameter int SPR_H = 4,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] c_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
    state_t state, state_n;
    logic [7:0] new_x, old_x, pend_x;
    logic [6:0] new_y, old_y, pend_y;
    logic [2:0] new_c, pend_c;
    logic       pending, has_drawn;
    logic [3:0] cx, cy;
    logic       last_x, last, start, active, erasing;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sx;
    logic [7:0] sy;
    assign last_x  = cx == 4'(SPR_W - 1);
    assign last    = last_x && cy == 4'(SPR_H - 1);
    assign start   = state == IDLE && (go || pending);
    assign erasing = state == ERASE;
    assign active  = erasing || state == DRAW;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = start ? (has_drawn ? ERASE : DRAW) : IDLE;
            ERASE: state_n = last ? DRAW : ERASE;
            DRAW:  state_n = last ? DONE : DRAW;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            new_x     <= '0;
            new_y     <= '0;
            new_c     <= '0;
            old_x     <= '0;
            old_y     <= '0;
            pend_x    <= '0;
            pend_y    <= '0;
            pend_c    <= '0;
            pending   <= 1'b0;
            has_drawn <= 1'b0;
            cx        <= '0;
            cy        <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                // a fresh go always beats a queued request, which is then dropped
                if (start) begin
                    new_x   <= go ? x_in : pend_x;
                    new_y   <= go ? y_in : pend_y;
                    new_c   <= go ? c_in : pend_c;
                    pending <= 1'b0;
                    cx      <= '0;
                    cy      <= '0;
                end
            end else if (go) begin
                pend_x  <= x_in;
                pend_y  <= y_in;
                pend_c  <= c_in;
                pending <= 1'b1;
            end
            if (active) begin
                cx <= last_x ? 4'd0 : cx + 4'd1;
                cy <= last ? 4'd0 : (last_x ? cy + 4'd1 : cy);
            end
            if (state == DRAW && last) begin
                old_x     <= new_x;
                old_y     <= new_y;
                has_drawn <= 1'b1;
            end
        end
    end
    // widened sums so off-screen pixels clip instead of wrapping
    assign base_x = erasing ? old_x : new_x;
    assign base_y = erasing ? old_y : new_y;
    assign sx     = {1'b0, base_x} + {5'b0, cx};
    assign sy     = {1'b0, base_y} + {4'b0, cy};
    assign x      = active ? sx[7:0] : 8'd0;
    assign y      = active ? sy[6:0] : 7'd0;
    assign colour = active ? (erasing ? BG_COLOUR : new_c) : 3'd0;
    assign plot   = active && sx < 9'd160 && sy < 8'd120;
    assign busy   = state != IDLE;
    assign done   = state == DONE;
endmodule

// File: doc/sprite_plotter.md
SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 Parameter SPR_W, default 4, sprite width in pixels (1..16).
REQ-002 Parameter SPR_H, default 4, sprite height in pixels (1..16).
REQ-003 Parameter BG_COLOUR, default 3'b000, colour used to erase the previous sprite.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 go  input  1  request to draw a sprite at x_in/y_in; sampled every rising edge.
REQ-007 x_in  input  8  sprite top-left column, 0..159 screen range.
REQ-008 y_in  input  7  sprite top-left row, 0..119 screen range.
REQ-009 c_in  input  3  sprite colour.
REQ-010 x  output  8  pixel column to the frame-buffer write port.
REQ-011 y  output  7  pixel row to the frame-buffer write port.
REQ-012 colour  output  3  pixel colour.
REQ-013 plot  output  1  write enable; the pixel on x/y/colour is valid this cycle.
REQ-014 busy  output  1  high in states ERASE, DRAW and DONE.
REQ-015 done  output  1  single-cycle pulse when a job completes.

Function
REQ-016 States: IDLE, ERASE, DRAW, DONE; all outputs SHALL be decoded from registers only (no input-to-output combinational path).
REQ-017 In IDLE with go=1: latch x_in/y_in/c_in as the new job, clear pixel counters; next state ERASE if has_drawn=1, else DRAW.
REQ-018 In IDLE with go=0 and pending=1: start the pending job exactly as REQ-017 and clear pending.
REQ-019 In IDLE with go=1 and pending=1 in the same cycle: go wins; pending is cleared and discarded.
REQ-020 go sampled in ERASE, DRAW or DONE SHALL load a one-deep pending register (x,y,c) and set pending; a later go overwrites it (latest wins).
REQ-021 Pixel counters cx (0..SPR_W-1, fastest) and cy (0..SPR_H-1) SHALL scan raster order, one pixel per cycle, no idle cycles inside a phase.
REQ-022 ERASE: x=old_x+cx, y=old_y+cy, colour=BG_COLOUR, where old_x/old_y are the coordinates of the last completed DRAW.
REQ-023 DRAW: x=new_x+cx, y=new_y+cy, colour=new colour.
REQ-024 At the last pixel of ERASE (cx=SPR_W-1, cy=SPR_H-1) counters clear and the next state is DRAW; at the last pixel of DRAW the next state is DONE.
REQ-025 Entering DONE SHALL copy new_x/new_y to old_x/old_y and set has_drawn; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-026 Latency: first pixel (offset 0,0) presented in the cycle immediately after the accepting edge; a job takes SPR_W*SPR_H cycles (first job) or 2*SPR_W*SPR_H cycles, plus one DONE cycle.
REQ-027 Address sums SHALL be computed at 9 bits (x) and 8 bits (y); a pixel with column >159 or row >119 SHALL have plot=0 but still consume its cycle (clipping, no wrap-around).
REQ-028 plot=1 only in ERASE/DRAW for unclipped pixels; plot=0, done=0 in IDLE.
REQ-029 x_in/y_in/c_in changes after acceptance SHALL NOT affect the job in progress.

Reset
REQ-030 resetn=0 SHALL immediately force state IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0, counters=0, pending=0, has_drawn=0, old_x=0, old_y=0.
REQ-031 Reset mid-job SHALL abandon the job with no further plot pulses; the next accepted job is treated as first (no ERASE).

Verification
REQ-032 After reset, go with (10,100,3'b010) -> 16 consecutive plot cycles covering x 10..13, y 100..103, colour 010, then done for 1 cycle.
REQ-033 Second go with (12,100,010) -> 16 plot cycles x 10..13/y 100..103 colour 000, then 16 cycles x 12..15 colour 010, then done.
REQ-034 go at (158,118) on first job -> 16 cycles, plot=1 only for x 158..159 and y 118..119 (4 pixels), done after 16 cycles.
REQ-035 Two go pulses (20,50) then (30,50) during a busy job -> after done, IDLE for one cycle, then job at (30,50) only; (20,50) never drawn.
REQ-036 go and pending both present in IDLE -> go coordinates drawn, pending discarded, no second job.
REQ-037 resetn pulsed low during DRAW pixel 5 -> plot=0 immediately, busy=0; next go produces 16 DRAW pixels with no ERASE.
